// File: rtl/i2c_pkg.sv
// Shared I2C definitions: 4-bit FSM state encodings (also used on the debug
// state port), R/W wire values and ACK/NACK wire levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_RX        = 4'd3,
        ST_RX_ACK    = 4'd4,
        ST_TX        = 4'd5,
        ST_TX_ACK    = 4'd6,
        ST_WAIT_STOP = 4'd7
    } i2c_state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;

endpackage

// File: rtl/i2c_peripheral_if.sv
// Host-side port bundle of the I2C peripheral: own address, byte handshakes,
// status and debug state. The peripheral uses the slave modport.
interface i2c_peripheral_if;
    import i2c_pkg::*;

    logic [6:0] periph_addr;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    i2c_state_t state;

    modport master (
        output periph_addr, tx_byte,
        input  rx_byte, rx_valid, tx_req, busy, state
    );

    modport slave (
        input  periph_addr, tx_byte,
        output rx_byte, rx_valid, tx_req, busy, state
    );

endinterface

// File: rtl/i2c_line_sync.sv
// Per-line input conditioning: 2-flop synchronizer, optional 3-sample majority
// filter (build macro I2C_PERIPH_GLITCH_FILTER_EN, +2 clk latency), edge detect.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic level,
    output logic rise,
    output logic fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic w_level;

    // Flops reset to the idle-high bus level so reset never manufactures an edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
        end
    end

`ifdef I2C_PERIPH_GLITCH_FILTER_EN
    logic [2:0] r_hist;
    logic       r_major;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist  <= 3'b111;
            r_major <= 1'b1;
        end else begin
            r_hist  <= {r_hist[1:0], r_sync};
            r_major <= (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
        end
    end

    assign w_level = r_major;
`else
    assign w_level = r_sync;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign level = w_level;
    assign rise  = w_level & ~r_prev;
    assign fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_peripheral.sv
// I2C target: oversampled START/STOP detection, 7-bit address match with ACK,
// write-byte delivery and read-byte shifting. Build macro: I2C_PERIPH_GLITCH_FILTER_EN.
module i2c_peripheral
    import i2c_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scl,
    inout  wire                     sda,
    i2c_peripheral_if.slave         bus
);
    logic w_scl_level, w_scl_rise, w_scl_fall;
    logic w_sda_level, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_shift_in;

    i2c_state_t r_state, w_state_next;
    logic [3:0] r_cnt, w_cnt_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_rw, w_rw_next;
    logic       r_sda_low, w_sda_low_next;
    logic [7:0] r_rx_byte, w_rx_byte_next;
    logic       r_rx_valid, w_rx_valid_next;
    logic       r_tx_req, w_tx_req_next;
    logic       r_busy, w_busy_next;

    i2c_line_sync u_scl_sync (
        .clk(clk), .reset(reset), .i_line(scl),
        .level(w_scl_level), .rise(w_scl_rise), .fall(w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk(clk), .reset(reset), .i_line(sda),
        .level(w_sda_level), .rise(w_sda_rise), .fall(w_sda_fall)
    );

    assign w_start    = w_sda_fall & w_scl_level;
    assign w_stop     = w_sda_rise & w_scl_level;
    assign w_shift_in = {r_shift[6:0], w_sda_level};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_rw       <= RW_WRITE;
            r_sda_low  <= 1'b0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_shift    <= w_shift_next;
            r_rw       <= w_rw_next;
            r_sda_low  <= w_sda_low_next;
            r_rx_byte  <= w_rx_byte_next;
            r_rx_valid <= w_rx_valid_next;
            r_tx_req   <= w_tx_req_next;
            r_busy     <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_shift_next    = r_shift;
        w_rw_next       = r_rw;
        w_sda_low_next  = r_sda_low;
        w_rx_byte_next  = r_rx_byte;
        w_rx_valid_next = 1'b0;
        w_tx_req_next   = 1'b0;
        w_busy_next     = r_busy;

        if (w_stop) begin
            w_state_next   = ST_IDLE;
            w_cnt_next     = '0;
            w_sda_low_next = 1'b0;
            w_busy_next    = 1'b0;
        end else if (w_start) begin
            w_state_next   = ST_ADDR;
            w_cnt_next     = '0;
            w_sda_low_next = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: if (w_scl_rise) begin
                    w_shift_next = w_shift_in;
                    w_cnt_next   = r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        w_cnt_next = '0;
                        if (w_shift_in[7:1] == bus.periph_addr) begin
                            w_state_next = ST_ADDR_ACK;
                            w_rw_next    = w_shift_in[0];
                            w_busy_next  = 1'b1;
                        end else begin
                            w_state_next = ST_WAIT_STOP;
                            w_busy_next  = 1'b0;
                        end
                    end
                end
                // First scl_fall opens the ACK drive window, the second closes it
                ST_ADDR_ACK, ST_RX_ACK: if (w_scl_fall) begin
                    if (!r_sda_low) begin
                        w_sda_low_next = 1'b1;
                        if (r_state == ST_ADDR_ACK && r_rw == RW_READ) begin
                            w_tx_req_next = 1'b1;
                            w_shift_next  = bus.tx_byte;
                        end
                    end else if (r_state == ST_ADDR_ACK && r_rw == RW_READ) begin
                        w_sda_low_next = ~r_shift[7];
                        w_shift_next   = {r_shift[6:0], 1'b0};
                        w_cnt_next     = 4'd1;
                        w_state_next   = ST_TX;
                    end else begin
                        w_sda_low_next = 1'b0;
                        w_cnt_next     = '0;
                        w_state_next   = ST_RX;
                    end
                end
                ST_RX: if (w_scl_rise) begin
                    w_shift_next = w_shift_in;
                    w_cnt_next   = r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        w_rx_byte_next  = w_shift_in;
                        w_rx_valid_next = 1'b1;
                        w_cnt_next      = '0;
                        w_state_next    = ST_RX_ACK;
                    end
                end
                // r_cnt counts bits already placed on the line
                ST_TX: if (w_scl_fall) begin
                    if (r_cnt == 4'd8) begin
                        w_sda_low_next = 1'b0;
                        w_cnt_next     = '0;
                        w_state_next   = ST_TX_ACK;
                    end else begin
                        w_sda_low_next = ~r_shift[7];
                        w_shift_next   = {r_shift[6:0], 1'b0};
                        w_cnt_next     = r_cnt + 4'd1;
                    end
                end
                // r_cnt == 1 marks an ACK already sampled and the next byte loaded
                ST_TX_ACK: begin
                    if (w_scl_rise && r_cnt == 4'd0) begin
                        if (w_sda_level == ACK) begin
                            w_tx_req_next = 1'b1;
                            w_shift_next  = bus.tx_byte;
                            w_cnt_next    = 4'd1;
                        end else begin
                            w_state_next = ST_WAIT_STOP;
                            w_busy_next  = 1'b0;
                        end
                    end else if (w_scl_fall && r_cnt == 4'd1) begin
                        w_sda_low_next = ~r_shift[7];
                        w_shift_next   = {r_shift[6:0], 1'b0};
                        w_state_next   = ST_TX;
                    end
                end
                ST_WAIT_STOP: w_sda_low_next = 1'b0;
                default: ;
            endcase
        end
    end

    assign sda          = r_sda_low ? 1'b0 : 1'bz;
    assign bus.rx_byte  = r_rx_byte;
    assign bus.rx_valid = r_rx_valid;
    assign bus.tx_req   = r_tx_req;
    assign bus.busy     = r_busy;
    assign bus.state    = r_state;

endmodule

// File: tb/tb_i2c_peripheral.sv
// Directed plus randomized bench for i2c_peripheral acting as a bit-level I2C controller.
module tb_i2c_peripheral;
    import i2c_pkg::*;

    localparam int H = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl = 1'b1;
    logic tb_sda_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = tb_sda_low ? 1'b0 : 1'bz;

    i2c_peripheral_if bus_if ();

    i2c_peripheral dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda), .bus(bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int rx_cnt = 0;
    int tx_req_cnt = 0;
    int dut_low_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_list[4];

    // Each tx_req consumes one queued read byte; the next one is presented right after
    assign bus_if.tx_byte = tx_list[tx_req_cnt[1:0]];

    always @(negedge clk) begin
        if (reset) begin
            if (bus_if.rx_valid) begin
                rx_cnt++;
                rx_q.push_back(bus_if.rx_byte);
            end
            if (bus_if.tx_req) tx_req_cnt++;
            if (sda === 1'b0 && !tb_sda_low) dut_low_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        rx_cnt = 0;
        tx_req_cnt = 0;
        dut_low_cnt = 0;
        rx_q.delete();
    endtask

    // START from idle, or repeated START from scl low
    task automatic bus_start();
        tb_sda_low = 1'b0; tick(H);
        scl = 1'b1;        tick(H);
        tb_sda_low = 1'b1; tick(H);
        scl = 1'b0;        tick(H);
    endtask

    task automatic bus_stop();
        tb_sda_low = 1'b1; tick(H);
        scl = 1'b1;        tick(H);
        tb_sda_low = 1'b0; tick(H);
    endtask

    task automatic bus_bit(input bit b, output bit s);
        tb_sda_low = ~b; tick(H);
        scl = 1'b1;      tick(H / 2);
        s = sda;         tick(H / 2);
        scl = 1'b0;      tick(H);
    endtask

    task automatic send_byte(input logic [7:0] d, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input bit ack_val, output logic [7:0] d);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(ack_val, s);
    endtask

    task automatic do_write(input string tag, input logic [6:0] a, input logic [7:0] d[$]);
        bit ack;
        bit hit;
        hit = (a == bus_if.periph_addr);
        clear_obs();
        bus_start();
        send_byte({a, RW_WRITE}, ack);
        chk({tag, " addr_ack"}, 32'(ack), 32'(hit ? ACK : NACK));
        chk({tag, " busy"}, 32'(bus_if.busy), 32'(hit));
        foreach (d[i]) begin
            send_byte(d[i], ack);
            chk({tag, " data_ack"}, 32'(ack), 32'(hit ? ACK : NACK));
        end
        if (!hit) chk({tag, " state_wait"}, 32'(bus_if.state), 32'(ST_WAIT_STOP));
        bus_stop();
        chk({tag, " state_idle"}, 32'(bus_if.state), 32'(ST_IDLE));
        chk({tag, " busy_after"}, 32'(bus_if.busy), 32'd0);
        chk({tag, " rx_count"}, 32'(rx_cnt), hit ? 32'(d.size()) : 32'd0);
        chk({tag, " tx_req_count"}, 32'(tx_req_cnt), 32'd0);
        if (hit) begin
            foreach (d[i]) if (i < rx_q.size()) chk({tag, " rx_seq"}, 32'(rx_q[i]), 32'(d[i]));
            chk({tag, " rx_byte"}, 32'(bus_if.rx_byte), 32'(d[d.size() - 1]));
        end else begin
            chk({tag, " dut_never_low"}, 32'(dut_low_cnt), 32'd0);
        end
        $display("write %s addr=%02h hit=%0d bytes=%0d rx_valid=%0d", tag, a, hit, d.size(), rx_cnt);
    endtask

    task automatic do_read(input string tag, input logic [6:0] a, input int n);
        bit ack;
        bit hit;
        logic [7:0] b;
        hit = (a == bus_if.periph_addr);
        clear_obs();
        bus_start();
        send_byte({a, RW_READ}, ack);
        chk({tag, " addr_ack"}, 32'(ack), 32'(hit ? ACK : NACK));
        chk({tag, " busy"}, 32'(bus_if.busy), 32'(hit));
        chk({tag, " tx_req_at_addr"}, 32'(tx_req_cnt), 32'(hit));
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                recv_byte((i == n - 1) ? NACK : ACK, b);
                chk({tag, " read_byte"}, 32'(b), 32'(tx_list[i]));
            end
        end
        chk({tag, " state_wait"}, 32'(bus_if.state), 32'(ST_WAIT_STOP));
        chk({tag, " busy_nack"}, 32'(bus_if.busy), 32'd0);
        bus_stop();
        chk({tag, " state_idle"}, 32'(bus_if.state), 32'(ST_IDLE));
        chk({tag, " tx_req_count"}, 32'(tx_req_cnt), hit ? 32'(n) : 32'd0);
        chk({tag, " rx_count"}, 32'(rx_cnt), 32'd0);
        if (!hit) chk({tag, " dut_never_low"}, 32'(dut_low_cnt), 32'd0);
        $display("read  %s addr=%02h hit=%0d bytes=%0d tx_req=%0d", tag, a, hit, n, tx_req_cnt);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] dq[$];
        logic [7:0] part;
        logic [6:0] pa;
        logic [6:0] a;
        bit ack;
        bit s;
        int n;

        bus_if.periph_addr = 7'd5;
        tx_list = '{default: 8'h00};

        reset = 1'b0;
        tick(5);
        chk("rst state", 32'(bus_if.state), 32'(ST_IDLE));
        chk("rst busy", 32'(bus_if.busy), 32'd0);
        chk("rst rx_byte", 32'(bus_if.rx_byte), 32'd0);
        chk("rst rx_valid", 32'(bus_if.rx_valid), 32'd0);
        chk("rst tx_req", 32'(bus_if.tx_req), 32'd0);
        chk("rst sda", 32'(sda), 32'd1);
        $display("reset checked");
        reset = 1'b1;
        tick(5);

        q = '{8'h07};
        do_write("wr07", 7'd5, q);
        do_write("miss6", 7'd6, q);

        tx_list[0] = 8'hA5;
        do_read("rdA5", 7'd5, 1);

        tx_list[0] = 8'h3C;
        tx_list[1] = 8'hC3;
        do_read("rd2", 7'd5, 2);

        // Repeated START after four data bits, then a full write
        clear_obs();
        bus_start();
        send_byte({7'd5, RW_WRITE}, ack);
        chk("rs addr_ack", 32'(ack), 32'(ACK));
        part = 8'hB0;
        for (int i = 7; i >= 4; i--) bus_bit(part[i], s);
        bus_start();
        send_byte({7'd5, RW_WRITE}, ack);
        chk("rs addr2_ack", 32'(ack), 32'(ACK));
        send_byte(8'h55, ack);
        bus_stop();
        chk("rs rx_count", 32'(rx_cnt), 32'd1);
        chk("rs rx_byte", 32'(bus_if.rx_byte), 32'h55);
        $display("repeated start: rx_valid=%0d rx_byte=%02h", rx_cnt, bus_if.rx_byte);

        // Reset asserted while the peripheral drives the data ACK
        clear_obs();
        bus_start();
        send_byte({7'd5, RW_WRITE}, ack);
        part = 8'hA3;
        for (int i = 7; i >= 0; i--) bus_bit(part[i], s);
        chk("rstack state", 32'(bus_if.state), 32'(ST_RX_ACK));
        chk("rstack sda_driven", 32'(sda), 32'd0);
        chk("rstack rx_byte", 32'(bus_if.rx_byte), 32'hA3);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rstack sda_released", 32'(sda), 32'd1);
        chk("rstack state_idle", 32'(bus_if.state), 32'(ST_IDLE));
        chk("rstack busy", 32'(bus_if.busy), 32'd0);
        chk("rstack rx_byte_clr", 32'(bus_if.rx_byte), 32'd0);
        chk("rstack rx_valid", 32'(bus_if.rx_valid), 32'd0);
        chk("rstack tx_req", 32'(bus_if.tx_req), 32'd0);
        $display("reset in ack window checked");
        tick(2);
        reset = 1'b1;
        tick(H);
        scl = 1'b1;
        tick(H);
        q = '{8'h9E};
        do_write("post_rst", 7'd5, q);

        for (int it = 0; it < 8; it++) begin
            pa = 7'($urandom);
            bus_if.periph_addr = pa;
            a = ($urandom_range(0, 3) != 0) ? pa : 7'(pa + 7'($urandom_range(1, 127)));
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) tx_list[i] = 8'($urandom);
                do_read("rnd_rd", a, n);
            end else begin
                dq.delete();
                for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
                do_write("rnd_wr", a, dq);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
